// File: rtl/trace_pkg.sv
// Purpose: shared types and default sizing for the a0 trace monitor.
// Contents: default DEPTH/TS_W/DROP_W, data width, default trace entry type.
package trace_pkg;

    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned TS_W_DEF   = 16;
    localparam int unsigned DROP_W_DEF = 8;
    localparam int unsigned DATA_W     = 32;

    // One recorded a0 change: value plus timestamp of the capture cycle.
    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [TS_W_DEF-1:0] ts;
    } trace_entry_t;

endpackage

// File: rtl/a0_trace_monitor_if.sv
// Purpose: signal bundle between the trace monitor and its driver/consumer.
// master: drives a0, en, out_ready, clear_ovf; observes the stream and status.
// slave : the monitor side (inputs/outputs reversed).
interface a0_trace_monitor_if #(
    parameter int unsigned DEPTH  = trace_pkg::DEPTH_DEF,
    parameter int unsigned TS_W   = trace_pkg::TS_W_DEF,
    parameter int unsigned DROP_W = trace_pkg::DROP_W_DEF
);
    import trace_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] a0;
    logic              en;
    logic              out_ready;
    logic              clear_ovf;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output a0, en, out_ready, clear_ovf,
        input  out_valid, out_data, out_ts, count, overflow, drop_cnt
    );

    modport slave (
        input  a0, en, out_ready, clear_ovf,
        output out_valid, out_data, out_ts, count, overflow, drop_cnt
    );

endinterface

// File: rtl/sync_fifo.sv
// Purpose: single-clock first-word-fall-through FIFO.
// Ports: clk, reset (async, active-high), i_push/i_data write side,
//        i_pop read side, o_head (head entry, zero while empty),
//        o_empty, o_full, o_count (occupancy).
// Callers must not push when full without a same-cycle pop, nor pop when empty.
module sync_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter type         T     = trace_entry_t,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output T                 o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    // Zero the head while empty so nothing uninitialised leaks out.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/a0_trace_monitor.sv
// Purpose: records every change of the CPU a0 register as a timestamped
//          entry in a FWFT FIFO, with sticky overflow and drop counter.
// Ports: clk, reset (async, active-high), bus (slave modport):
//        a0/en capture inputs, out_valid/out_ready/out_data/out_ts stream,
//        count occupancy, overflow/drop_cnt/clear_ovf loss reporting.
module a0_trace_monitor
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TS_W   = TS_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    a0_trace_monitor_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Entry type sized by this instance's timestamp width.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    logic [DATA_W-1:0] r_a0_q;
    logic [TS_W-1:0]   r_ts;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic             w_evt;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    entry_t           w_entry;
    entry_t           w_head;
    logic [CNT_W-1:0] w_count;

    assign w_evt   = bus.en && (bus.a0 != r_a0_q);
    assign w_pop   = !w_empty && bus.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = w_evt && (!w_full || w_pop);
    assign w_drop  = w_evt && w_full && !w_pop;
    assign w_entry = '{data: bus.a0, ts: r_ts};

    // Previous-value tracker runs regardless of en; timestamp free-runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a0_q <= '0;
            r_ts   <= '0;
        end else begin
            r_a0_q <= bus.a0;
            r_ts   <= r_ts + TS_W'(1);
        end
    end

    // Loss reporting; a drop coinciding with a clear counts as the first drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (bus.clear_ovf) begin
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? DROP_W'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head.data;
    assign bus.out_ts    = w_head.ts;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_a0_trace_monitor.sv
// Purpose: scoreboard bench for a0_trace_monitor. Stimulus pushes hand-derived
// expected entries into a queue; a monitor pops and compares on each pop.
module tb_a0_trace_monitor;

    typedef struct {
        logic [31:0] data;
        logic [15:0] ts;
    } exp_t;

    logic clk;
    logic reset;
    logic rst4;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    a0_trace_monitor_if #(.DEPTH(16), .TS_W(16), .DROP_W(8)) bus ();
    a0_trace_monitor_if #(.DEPTH(16), .TS_W(4),  .DROP_W(8)) bus4 ();

    a0_trace_monitor #(.DEPTH(16), .TS_W(16), .DROP_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    a0_trace_monitor #(.DEPTH(16), .TS_W(4), .DROP_W(8)) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; equals the timestamp a capture will carry.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [15:0] t);
        exp_t e;
        e.data = d;
        e.ts   = t;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the head against the scoreboard whenever a pop is about to occur.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_entry: got data 0x%0h ts 0x%0h, expected none",
                             bus.out_data, bus.out_ts);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 64'(bus.out_data), 64'(e.data));
                    chk("pop_ts",   64'(bus.out_ts),   64'(e.ts));
                end
            end
        end
    endtask

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        fork
            monitor();
        join_none

        reset = 1'b1; bus.a0 = 32'h5; bus.en = 1'b1; bus.out_ready = 1'b0; bus.clear_ovf = 1'b0;
        rst4  = 1'b1; bus4.a0 = 32'h0; bus4.en = 1'b1; bus4.out_ready = 1'b0; bus4.clear_ovf = 1'b0;

        // Reset values, then first edge captures a0=5 against a0_q=0.
        #12;
        chk("rst_valid",    64'(bus.out_valid), 64'd0);
        chk("rst_data",     64'(bus.out_data),  64'd0);
        chk("rst_ts",       64'(bus.out_ts),    64'd0);
        chk("rst_count",    64'(bus.count),     64'd0);
        chk("rst_overflow", 64'(bus.overflow),  64'd0);
        chk("rst_drop",     64'(bus.drop_cnt),  64'd0);
        reset = 1'b0;
        push_exp(32'h5, 16'd0);
        tick();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data",  64'(bus.out_data),  64'h5);
        chk("t1_ts",    64'(bus.out_ts),    64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_count_after_pop", 64'(bus.count), 64'd0);

        // Single change at cycle 10.
        for (int i = 0; i < 40 && cyc != 10; i++) tick();
        bus.a0 = 32'h2A;
        push_exp(32'h2A, 16'd10);
        tick();
        chk("t2_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_data",  64'(bus.out_data),  64'h2A);
        chk("t2_ts",    64'(bus.out_ts),    64'd10);
        chk("t2_count", 64'(bus.count),     64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_count_pop", 64'(bus.count),     64'd0);
        chk("t2_valid_pop", 64'(bus.out_valid), 64'd0);

        // Enable gating: a0_q follows a0 while disabled.
        bus.en = 1'b0;
        bus.a0 = 32'h7;
        tick();
        tick();
        bus.en = 1'b1;
        tick();
        tick();
        chk("t3_count", 64'(bus.count),     64'd0);
        chk("t3_valid", 64'(bus.out_valid), 64'd0);

        // Overflow: 20 changes into 16 entries.
        for (int i = 0; i < 20; i++) begin
            bus.a0 = 32'h100 + 32'(i);
            if (i < 16) push_exp(32'h100 + 32'(i), 16'(cyc));
            tick();
        end
        chk("t4_count",    64'(bus.count),    64'd16);
        chk("t4_overflow", 64'(bus.overflow), 64'd1);
        chk("t4_drop",     64'(bus.drop_cnt), 64'd4);
        chk("t4_head",     64'(bus.out_data), 64'h100);
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        chk("t4_clr_overflow", 64'(bus.overflow), 64'd0);
        chk("t4_clr_drop",     64'(bus.drop_cnt), 64'd0);

        // Full FIFO with simultaneous pop accepts the new entry.
        bus.a0 = 32'h200;
        bus.out_ready = 1'b1;
        push_exp(32'h200, 16'(cyc));
        tick();
        bus.out_ready = 1'b0;
        chk("t5_count",    64'(bus.count),    64'd16);
        chk("t5_overflow", 64'(bus.overflow), 64'd0);
        chk("t5_drop",     64'(bus.drop_cnt), 64'd0);

        // Drop in the same cycle as a clear leaves one recorded drop.
        bus.a0 = 32'h300;
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        chk("t5_clrdrop_overflow", 64'(bus.overflow), 64'd1);
        chk("t5_clrdrop_drop",     64'(bus.drop_cnt), 64'd1);

        // Drain; the tail must be the entry accepted while full.
        bus.out_ready = 1'b1;
        repeat (16) tick();
        bus.out_ready = 1'b0;
        chk("t5_drained", 64'(bus.count), 64'd0);

        // Reset mid-stream empties the FIFO asynchronously.
        for (int i = 0; i < 5; i++) begin
            bus.a0 = 32'h400 + 32'(i);
            push_exp(32'h400 + 32'(i), 16'(cyc));
            tick();
        end
        chk("t6_count_fill", 64'(bus.count), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_count", 64'(bus.count),     64'd0);
        chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        #3;
        reset = 1'b0;
        push_exp(32'h404, 16'd0);
        tick();
        chk("t6_post_count", 64'(bus.count),    64'd1);
        chk("t6_post_data",  64'(bus.out_data), 64'h404);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // 4-bit timestamp wraps: event at cycle 17 carries ts 1.
        rst4 = 1'b0;
        repeat (17) tick();
        bus4.a0 = 32'h9;
        tick();
        chk("t6_wrap_valid", 64'(bus4.out_valid), 64'd1);
        chk("t6_wrap_data",  64'(bus4.out_data),  64'h9);
        chk("t6_wrap_ts",    64'(bus4.out_ts),    64'd1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/a0_trace_monitor.md
# a0_trace_monitor

Observation block downstream of the CPU top level. It watches the CPU's 32-bit `a0` result register every cycle and records each change as a timestamped entry in an on-chip FIFO. A host or testbench drains the FIFO over a valid/ready stream. Overflow is reported by a sticky flag and a saturating drop counter, so no `a0` change is ever lost silently.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `TS_W`, 16: timestamp width in bits.
- `DROP_W`, 8: width of the drop counter.
- `clk` in, 1: single clock, rising-edge.
- `reset` in, 1: asynchronous, active-high reset.
- `a0` in, 32: CPU `a0` register value.
- `en` in, 1: capture enable.
- `out_ready` in, 1: consumer accepts the head entry.
- `clear_ovf` in, 1: clears `overflow` and `drop_cnt`.
- `out_valid` out, 1: FIFO non-empty.
- `out_data` out, 32: `a0` value of the head entry.
- `out_ts` out, TS_W: timestamp of the head entry.
- `count` out, $clog2(DEPTH)+1: current occupancy.
- `overflow` out, 1: sticky; set when any change is dropped.
- `drop_cnt` out, DROP_W: number of dropped changes, saturating.

## Operation
- **Reset values.** All outputs are 0 at reset: `out_valid`, `out_data`, `out_ts`, `count`, `overflow`, `drop_cnt`. Internal state also resets: `a0_q` = 0, `ts` = 0, read/write pointers = 0.
- **Previous-value register.** `a0_q` loads `a0` on every edge, regardless of `en`.
- **Timestamp.** `ts` increments by 1 every edge and wraps from 2^TS_W−1 to 0.
- **Event.** `evt = en && (a0 != a0_q)`. Because `a0_q` resets to 0, a nonzero `a0` after reset produces an event.
- **Entry.** Each entry is {`a0`, `ts`}, using the values present in the cycle of the event.
- **Push.** `push = evt && (!full || pop)`. A full FIFO accepts a push when a pop occurs in the same cycle.
- **Pop.** `pop = out_valid && out_ready`. `out_ready` is ignored while the FIFO is empty.
- **Drop.** A drop occurs when `evt && full && !pop`. On a drop:
  - `overflow` is set.
  - `drop_cnt` increments, saturating at 2^DROP_W−1.
- **Clear.** `clear_ovf` zeroes `overflow` and `drop_cnt`. If a drop happens in the same cycle, the result is `overflow` = 1 and `drop_cnt` = 1.
- **Occupancy update.** `count` changes by +1 on push only, −1 on pop only, and stays unchanged on push+pop.
- **Output stream.** The output is first-word-fall-through: `out_data`/`out_ts` always present the head entry while `out_valid` is high. Their value while empty is don't-care; the bench must not check it.
- **Stream stability.** Once `out_valid` is high, `out_valid`, `out_data` and `out_ts` hold until a pop.
- **Pointers.** Read and write pointers wrap modulo DEPTH. Full/empty is derived from `count`.

## Timing
- **Capture latency.** An event evaluated in cycle k is written at edge k. `out_valid` rises after edge k, giving 1-cycle latency from `a0` change to visibility on an empty FIFO.
- **Throughput.** One push and one pop per cycle, sustained indefinitely.
- **Back-to-back events.** `a0` changing every cycle produces one entry per cycle.
- **Pop latency.** A pop at edge k advances the head; the next entry, or `out_valid` = 0, is visible after edge k.
- **Reset mid-operation.** Asserting `reset` empties the FIFO immediately (asynchronously) and clears all state. The first edge after deassertion compares against `a0_q` = 0.
- **Overflow and clear latency.** `overflow` and `drop_cnt` update at the same edge as the dropped event or the clear.

## Structure
- **Shared package `trace_pkg`:**
  - `trace_entry_t` struct {`logic [31:0] data`; `logic [TS_W-1:0] ts`}.
  - Default constants for DEPTH, TS_W and DROP_W.
- **Sub-module `sync_fifo`:**
  - Parameterised on DEPTH and entry type.
  - FWFT read, push/pop, count, full/empty.
  - Asynchronous active-high reset.
- **Top logic of `a0_trace_monitor`:** change detection, timestamp counter, drop/overflow logic.

## Test plan
1. **Reset values.** Hold `reset` high with `a0` = 0x5. Expect every output = 0. Deassert `reset`; after 1 edge expect `out_valid` = 1, `out_data` = 0x5, `out_ts` = 0.
2. **Single change.** Set `a0` 0→0x2A in cycle 10 with `en` = 1 and `out_ready` = 0. Expect `out_valid` = 1, `out_data` = 0x2A, `out_ts` = 10, `count` = 1. Pulse `out_ready`; expect `count` = 0 and `out_valid` = 0.
3. **Enable gating.** With `en` = 0, change `a0` to 0x7 and hold it. Then set `en` = 1. Expect no entry, because `a0_q` already tracked the value.
4. **Overflow.** With DEPTH = 16 and `out_ready` = 0, change `a0` on 20 consecutive cycles. Expect `count` = 16, `overflow` = 1, `drop_cnt` = 4, and the head equal to the first change. Pulse `clear_ovf`; expect `overflow` = 0 and `drop_cnt` = 0.
5. **Full with simultaneous pop.** With the FIFO full, present a new change and `out_ready` = 1 in the same cycle. Expect `count` to stay 16, no drop, and the new entry stored at the tail.
6. **Reset mid-stream and timestamp wrap.**
   - Fill 5 entries, then assert `reset` asynchronously between edges. Expect `count` = 0 and `out_valid` = 0 immediately.
   - Separately, with TS_W = 4, trigger an event at cycle 17. Expect `out_ts` = 1.
